sevenseg_scan_ctrl: RTL

- Time-multiplexed 8-digit seven-segment driver sitting between the SoC register bus and the board pins AN[7:0], CA..CG and DP.
- Software writes value, enable and decimal-point registers into a pending bank. The bank is copied to the display shadow only at frame boundaries, so a display never tears.
- Each digit is hex-decoded and scanned with a programmable blanking gap to suppress ghosting.

---
 rtl/sevenseg_pkg.sv | 22 ++
 rtl/sevenseg_hex_dec.sv | 11 +
 rtl/sevenseg_scan_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the time-multiplexed seven-segment scan controller.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        SEL_VALUE  = 2'd0,
        SEL_ENABLE = 2'd1,
        SEL_DP     = 2'd2,
        SEL_RSVD   = 2'd3
    } wr_sel_e;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {a,b,c,d,e,f,g}, indexed by hex nibble 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/sevenseg_hex_dec.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sevenseg_hex_dec
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// 8-digit seven-segment scanner with a pending register bank that is copied
// into the display shadow only at frame boundaries, plus a per-slot blanking gap.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [1:0]  i_wr_sel,
    input  logic [31:0] i_wr_data,
    output logic [7:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    logic [31:0] pend_value, pend_value_nxt, sh_value;
    logic [7:0]  pend_en,    pend_en_nxt,    sh_en;
    logic [7:0]  pend_dp,    pend_dp_nxt,    sh_dp;

    logic       slot_end;
    logic       frame_end;
    logic       in_blank;
    logic       digit_on;
    logic [3:0] nibble;
    logic [6:0] seg_dec;

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == 3'd7);
    assign in_blank  = (int'(cnt) < BLANK_CYC);
    assign digit_on  = !in_blank && sh_en[idx];
    assign nibble    = sh_value[{idx, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 3'd0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx + 3'd1;
        end
    end

    // The next-value of the pending bank feeds the shadow so a boundary-cycle write lands this frame
    always_comb begin
        pend_value_nxt = pend_value;
        pend_en_nxt    = pend_en;
        pend_dp_nxt    = pend_dp;
        if (i_wr_en) begin
            case (wr_sel_e'(i_wr_sel))
                SEL_VALUE:  pend_value_nxt = i_wr_data;
                SEL_ENABLE: pend_en_nxt    = i_wr_data[7:0];
                SEL_DP:     pend_dp_nxt    = i_wr_data[7:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value <= '0;
            pend_en    <= '0;
            pend_dp    <= '0;
            sh_value   <= '0;
            sh_en      <= '0;
            sh_dp      <= '0;
        end else begin
            pend_value <= pend_value_nxt;
            pend_en    <= pend_en_nxt;
            pend_dp    <= pend_dp_nxt;
            if (frame_end) begin
                sh_value <= pend_value_nxt;
                sh_en    <= pend_en_nxt;
                sh_dp    <= pend_dp_nxt;
            end
        end
    end

    sevenseg_hex_dec u_hex_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_an         <= AN_OFF;
            o_seg        <= SEG_OFF;
            o_dp         <= 1'b1;
            o_frame_done <= 1'b0;
        end else begin
            o_an         <= digit_on ? ~(8'b1 << idx) : AN_OFF;
            o_seg        <= digit_on ? seg_dec : SEG_OFF;
            o_dp         <= digit_on ? ~sh_dp[idx] : 1'b1;
            o_frame_done <= frame_end;
        end
    end

endmodule
